// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
// Instruction sequencer for a small 8-bit CPU. It fetches opcodes from program
// ROM, waits one cycle for the registered decoder, then dispatches into one of:
//   * an operand fetch from ROM,
//   * a RAM read,
//   * a RAM write,
//   * an ALU operation.
// Every request/ack or start/done wait is bounded by ACK_TIMEOUT. Running out
// of time, or an illegal decode, parks the sequencer in TRAP until reset.
//
// Ports
//   clk, rst         : clock; asynchronous active-high reset
//   run              : sampled in IDLE only; 1 = fetch next instruction
//   rom_req/addr     : program-ROM read request, address = pc
//   rom_ack/data     : ROM acknowledge and read data
//   ram_req/we/addr  : internal-RAM request, write enable, address
//   ram_wdata        : RAM write data (acc_in captured at dispatch)
//   ram_rdata/ack    : RAM read data and acknowledge
//   instruction      : instruction register, feeds the decoder
//   dec_status       : registered decoder result
//   acc_in           : accumulator, source of RAM write data
//   operand          : last fetched operand
//   alu_start/done   : one-cycle ALU start strobe and ALU completion
//   pc               : program counter
//   trap, trap_code  : trap flag; code 01 = illegal, 10 = timeout
// -----------------------------------------------------------------------------
module cpu_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        rom_req,
    output logic [15:0] rom_addr,
    input  logic        rom_ack,
    input  logic [7:0]  rom_data,
    output logic        ram_req,
    output logic        ram_we,
    output logic [7:0]  ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    input  logic        ram_ack,
    output logic [7:0]  instruction,
    input  logic [2:0]  dec_status,
    input  logic [7:0]  acc_in,
    output logic [7:0]  operand,
    output logic        alu_start,
    input  logic        alu_done,
    output logic [15:0] pc,
    output logic        trap,
    output logic [1:0]  trap_code
);

    typedef enum logic [3:0] {
        IDLE, FETCH, DEC_WAIT, DISPATCH, RAM_RD,
        ROM_RD, PROCESS, ALU_WAIT, RAM_WR, TRAP
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [7:0]  r_instruction;
    logic [7:0]  r_operand;
    logic [7:0]  r_wdata;
    logic [7:0]  r_wait;
    logic [1:0]  r_trap_code;

    state_t      w_state_next;
    logic [15:0] w_pc_next;
    logic [7:0]  w_instruction_next;
    logic [7:0]  w_operand_next;
    logic [7:0]  w_wdata_next;
    logic [7:0]  w_wait_next;
    logic [1:0]  w_trap_code_next;

    logic        w_waiting;
    logic        w_ack;
    logic [7:0]  w_wait_inc;
    logic        w_timeout;

    // The ack or done that ends the current wait state. Acks belonging to a
    // port that is not currently requesting are never looked at.
    always_comb begin
        w_waiting = 1'b1;
        w_ack     = 1'b0;
        case (r_state)
            FETCH, ROM_RD:  w_ack = rom_ack;
            RAM_RD, RAM_WR: w_ack = ram_ack;
            ALU_WAIT:       w_ack = alu_done;
            default:        w_waiting = 1'b0;
        endcase
    end

    assign w_wait_inc = r_wait + 8'd1;
    assign w_timeout  = (w_wait_inc == ACK_TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_instruction <= 8'h00;
            r_operand     <= 8'h00;
            r_wdata       <= 8'h00;
            r_wait        <= 8'h00;
            r_trap_code   <= 2'b00;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_instruction <= w_instruction_next;
            r_operand     <= w_operand_next;
            r_wdata       <= w_wdata_next;
            r_wait        <= w_wait_next;
            r_trap_code   <= w_trap_code_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_instruction_next = r_instruction;
        w_operand_next     = r_operand;
        w_wdata_next       = r_wdata;
        w_wait_next        = r_wait;
        w_trap_code_next   = r_trap_code;

        // Shared bounded-wait behaviour; the per-state case below overrides
        // it when the ack or done actually arrives.
        if (w_waiting && !w_ack) begin
            if (w_timeout) begin
                w_state_next     = TRAP;
                w_trap_code_next = 2'b10;
            end else begin
                w_wait_next = w_wait_inc;
            end
        end

        case (r_state)
            IDLE: begin
                if (run) begin
                    w_state_next = FETCH;
                    w_wait_next  = 8'h00;
                end
            end
            FETCH: begin
                if (rom_ack) begin
                    w_instruction_next = rom_data;
                    w_pc_next          = r_pc + 16'd1;
                    w_state_next       = DEC_WAIT;
                end
            end
            DEC_WAIT: w_state_next = DISPATCH;
            DISPATCH: begin
                w_wait_next = 8'h00;
                case (dec_status)
                    3'b000: w_state_next = IDLE;
                    3'b001: w_state_next = RAM_RD;
                    3'b010: w_state_next = ROM_RD;
                    3'b011: w_state_next = PROCESS;
                    3'b100: begin
                        w_state_next = RAM_WR;
                        // Freeze write data so it cannot move during the request.
                        w_wdata_next = acc_in;
                    end
                    default: begin
                        w_state_next     = TRAP;
                        w_trap_code_next = 2'b01;
                    end
                endcase
            end
            RAM_RD: begin
                if (ram_ack) begin
                    w_operand_next = ram_rdata;
                    w_state_next   = PROCESS;
                end
            end
            ROM_RD: begin
                if (rom_ack) begin
                    w_operand_next = rom_data;
                    w_pc_next      = r_pc + 16'd1;
                    w_state_next   = PROCESS;
                end
            end
            PROCESS: begin
                w_state_next = ALU_WAIT;
                w_wait_next  = 8'h00;
            end
            ALU_WAIT: if (alu_done) w_state_next = IDLE;
            RAM_WR:   if (ram_ack) w_state_next = IDLE;
            TRAP:     w_state_next = TRAP;
            default:  w_state_next = IDLE;
        endcase
    end

    // Moore outputs: the requests follow the state register alone, so they
    // hold for the whole state and fall immediately on asynchronous reset.
    assign rom_req     = (r_state == FETCH) || (r_state == ROM_RD);
    assign rom_addr    = r_pc;
    assign ram_req     = (r_state == RAM_RD) || (r_state == RAM_WR);
    assign ram_we      = (r_state == RAM_WR);
    assign ram_addr    = {5'b00000, r_instruction[2:0]};
    assign ram_wdata   = r_wdata;
    assign alu_start   = (r_state == PROCESS);
    assign trap        = (r_state == TRAP);
    assign trap_code   = r_trap_code;
    assign instruction = r_instruction;
    assign operand     = r_operand;
    assign pc          = r_pc;

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 8'd255, maximum cycles any req may wait for its ack.
REQ-003 SHALL have port clk input 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst input 1, asynchronous active-high reset.
REQ-005 SHALL have port run input 1; 1 = fetch next instruction, 0 = hold in IDLE at instruction boundary.
REQ-006 SHALL have ports rom_req output 1, rom_addr output 16, rom_ack input 1, rom_data input 8, forming the program-ROM read port.
REQ-007 SHALL have ports ram_req output 1, ram_we output 1, ram_addr output 8, ram_wdata output 8, ram_rdata input 8, ram_ack input 1, forming the internal-RAM port.
REQ-008 SHALL have port instruction output 8, the instruction register, driven to the decoder.
REQ-009 SHALL have port dec_status input 3, the registered decoder result: 000 NOP, 001 RAM read, 010 ROM read, 011 process, 100 RAM write, 111 not done/illegal.
REQ-010 SHALL have ports acc_in input 8 (write data source), operand output 8 (last fetched operand), alu_start output 1, alu_done input 1.
REQ-011 SHALL have ports pc output 16, trap output 1, trap_code output 2 (01 illegal, 10 timeout).

Function
REQ-012 SHALL implement states IDLE, FETCH, DEC_WAIT, DISPATCH, RAM_RD, ROM_RD, PROCESS, ALU_WAIT, RAM_WR, TRAP.
REQ-013 IDLE: when run=1, go to FETCH next cycle; run=0 stays IDLE; run SHALL be sampled only in IDLE.
REQ-014 FETCH: rom_req=1, rom_addr=pc; on rom_ack=1, instruction<=rom_data, pc<=pc+1, go to DEC_WAIT.
REQ-015 DEC_WAIT SHALL last exactly 1 cycle to cover the decoder's register stage, then go to DISPATCH.
REQ-016 DISPATCH SHALL go on dec_status: 000 to IDLE; 001 to RAM_RD; 010 to ROM_RD; 011 to PROCESS; 100 to RAM_WR; 101/110/111 to TRAP with trap_code=01.
REQ-017 ROM_RD: rom_req=1, rom_addr=pc; on ack, operand<=rom_data, pc<=pc+1, go to PROCESS.
REQ-018 RAM_RD: ram_req=1, ram_we=0, ram_addr={5'b0,instruction[2:0]}; on ack, operand<=ram_rdata, go to PROCESS.
REQ-019 RAM_WR: ram_req=1, ram_we=1, same ram_addr rule, ram_wdata=acc_in; on ack go to IDLE.
REQ-020 PROCESS: alu_start=1 for exactly one cycle, then ALU_WAIT; ALU_WAIT on alu_done=1 goes to IDLE; alu_done outside ALU_WAIT SHALL be ignored.
REQ-021 Handshake: req is Moore (asserted for whole state); ack may arrive in the first req cycle; req SHALL deassert the cycle after ack is sampled; rom_addr/ram_addr/ram_we/ram_wdata SHALL be stable while req=1.
REQ-022 Acks arriving while the matching req=0 SHALL be ignored.
REQ-023 Wait counter: 8-bit, cleared on entry to FETCH/ROM_RD/RAM_RD/RAM_WR/ALU_WAIT, +1 per cycle without ack/done; on reaching ACK_TIMEOUT go to TRAP, trap_code=10, req dropped.
REQ-024 pc SHALL wrap 16'hFFFF to 16'h0000 without flag.
REQ-025 TRAP: trap=1, all reqs and alu_start 0, state and trap_code held until rst.
REQ-026 Minimum NOP instruction = 4 cycles (IDLE, FETCH with same-cycle ack, DEC_WAIT, DISPATCH).

Reset
REQ-027 On rst=1 (asynchronous), SHALL immediately set state=IDLE, pc=RESET_PC, instruction=8'h00, operand=8'h00, rom_req=ram_req=ram_we=alu_start=0, trap=0, trap_code=00, wait counter=0.
REQ-028 Reset mid-handshake SHALL drop req in the same cycle; no pc increment or register load from the aborted transfer.

Verification
REQ-029 NOP: run=1, ROM@0000=00, dec_status=000, ack same cycle -> instruction=00, pc=0001, back in IDLE after 4 cycles, no ram_req.
REQ-030 MOV A,#data: ROM 74,5A, dec_status=010, acks 2 cycles late -> operand=5A, pc=0002, one-cycle alu_start, IDLE after alu_done.
REQ-031 MOV R3,A: instruction FB, dec_status=100, acc_in=C3 -> ram_req=1, ram_we=1, ram_addr=03, ram_wdata=C3 until ack; IDLE next.
REQ-032 Illegal: dec_status=111 -> trap=1, trap_code=01, no further reqs for 100 cycles regardless of run.
REQ-033 Timeout with ACK_TIMEOUT=4: rom_ack held 0 -> TRAP with trap_code=10 exactly 4 cycles after FETCH entry; pc unchanged.
REQ-034 RESET_PC=FFFF, NOP fetch -> pc=0000 after ack; rst asserted during RAM_RD -> ram_req=0 immediately, pc=FFFF, state IDLE.
